// File: rtl/cc_game_status_monitor.sv
// Game status monitor: classifies sampled rows as win/lose candidates, confirms a
// result over CONFIRM consecutive strobes, latches it until ack, and counts wins.
module cc_game_status_monitor #(
  parameter int DATAWIDTH   = 8,
  parameter int CONFIRM     = 2,
  parameter int LEVEL_WIDTH = 4
) (
  input  logic                   CC_GameStatus_CLOCK_50,
  input  logic                   CC_GameStatus_RESET_InLow,
  input  logic                   CC_GameStatus_clear_InHigh,
  input  logic                   CC_GameStatus_strobe_InHigh,
  input  logic                   CC_GameStatus_ack_InHigh,
  input  logic [DATAWIDTH-1:0]   CC_GameStatus_dataOR_InBUS,
  input  logic [DATAWIDTH-1:0]   CC_GameStatus_dataFirst_InBUS,
  output logic [1:0]             CC_GameStatus_status_OutBUS,
  output logic                   CC_GameStatus_event_OutHigh,
  output logic [LEVEL_WIDTH-1:0] CC_GameStatus_level_OutBUS
);

  localparam int CNT_W = $clog2(CONFIRM + 1);
  localparam bit SINGLE = (CONFIRM == 1);

  typedef enum logic [1:0] {PLAY, ARMED, WIN, LOSE} state_t;
  typedef enum logic [1:0] {NONE, WINQ, LOSEQ} cls_t;

  logic                   clk;
  logic                   rst_n;
  state_t                 state;
  cls_t                   cand;
  cls_t                   cls;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             status;
  logic                   event_q;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   hit;

  assign clk   = CC_GameStatus_CLOCK_50;
  assign rst_n = CC_GameStatus_RESET_InLow;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cls = NONE;
    if (CC_GameStatus_strobe_InHigh) begin
      if (CC_GameStatus_dataOR_InBUS == {DATAWIDTH{1'b1}})
        cls = WINQ;
      else if (CC_GameStatus_dataOR_InBUS != CC_GameStatus_dataFirst_InBUS)
        cls = LOSEQ;
    end
    // A qualifying strobe that completes the confirmation run enters a terminal state.
    hit = 1'b0;
    if (state == PLAY && cls != NONE && SINGLE)
      hit = 1'b1;
    else if (state == ARMED && cls == cand && cnt == CNT_W'(CONFIRM - 1))
      hit = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PLAY;
      cand    <= NONE;
      cnt     <= '0;
      status  <= 2'b00;
      event_q <= 1'b0;
      level   <= '0;
    end else if (CC_GameStatus_clear_InHigh) begin
      state   <= PLAY;
      cand    <= NONE;
      cnt     <= '0;
      status  <= 2'b00;
      event_q <= 1'b0;
      level   <= '0;
    end else begin
      event_q <= 1'b0;
      case (state)
        PLAY, ARMED: begin
          if (hit) begin
            state   <= (cls == WINQ) ? WIN : LOSE;
            status  <= (cls == WINQ) ? 2'b11 : 2'b01;
            event_q <= 1'b1;
            cnt     <= CNT_W'(CONFIRM);
            if (cls == WINQ && level != {LEVEL_WIDTH{1'b1}})
              level <= level + 1'b1;
          end else if (cls != NONE) begin
            if (state == PLAY || cls != cand) begin
              cand  <= cls;
              cnt   <= CNT_W'(1);
              state <= ARMED;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (CC_GameStatus_strobe_InHigh && state == ARMED) begin
            // A non-qualifying sample breaks the run.
            state <= PLAY;
            cand  <= NONE;
            cnt   <= '0;
          end
        end
        WIN, LOSE: begin
          if (CC_GameStatus_ack_InHigh) begin
            state  <= PLAY;
            cand   <= NONE;
            cnt    <= '0;
            status <= 2'b00;
          end
        end
        default: begin
          state  <= PLAY;
          cand   <= NONE;
          cnt    <= '0;
          status <= 2'b00;
        end
      endcase
    end
  end

  assign CC_GameStatus_status_OutBUS = status;
  assign CC_GameStatus_event_OutHigh = event_q;
  assign CC_GameStatus_level_OutBUS  = level;

endmodule

// File: tb/tb_cc_game_status_monitor.sv
// Scoreboard bench for cc_game_status_monitor: two instances (LEVEL_WIDTH 4 and 2)
// share stimulus; directed steps queue expected outputs checked after each edge.
module tb_cc_game_status_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       strobe = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data_or = 8'h00;
  logic [7:0] data_first = 8'h00;
  logic [1:0] status_a, status_b;
  logic       event_a, event_b;
  logic [3:0] level_a;
  logic [1:0] level_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      nm;
    logic [1:0] st;
    logic       ev;
    logic [3:0] lv;
    logic [1:0] lv2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cc_game_status_monitor #(.DATAWIDTH(8), .CONFIRM(2), .LEVEL_WIDTH(4)) dut_a (
    .CC_GameStatus_CLOCK_50       (clk),
    .CC_GameStatus_RESET_InLow    (rst_n),
    .CC_GameStatus_clear_InHigh   (clear),
    .CC_GameStatus_strobe_InHigh  (strobe),
    .CC_GameStatus_ack_InHigh     (ack),
    .CC_GameStatus_dataOR_InBUS   (data_or),
    .CC_GameStatus_dataFirst_InBUS(data_first),
    .CC_GameStatus_status_OutBUS  (status_a),
    .CC_GameStatus_event_OutHigh  (event_a),
    .CC_GameStatus_level_OutBUS   (level_a)
  );

  cc_game_status_monitor #(.DATAWIDTH(8), .CONFIRM(2), .LEVEL_WIDTH(2)) dut_b (
    .CC_GameStatus_CLOCK_50       (clk),
    .CC_GameStatus_RESET_InLow    (rst_n),
    .CC_GameStatus_clear_InHigh   (clear),
    .CC_GameStatus_strobe_InHigh  (strobe),
    .CC_GameStatus_ack_InHigh     (ack),
    .CC_GameStatus_dataOR_InBUS   (data_or),
    .CC_GameStatus_dataFirst_InBUS(data_first),
    .CC_GameStatus_status_OutBUS  (status_b),
    .CC_GameStatus_event_OutHigh  (event_b),
    .CC_GameStatus_level_OutBUS   (level_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    check({e.nm, ".status"},  32'(status_a), 32'(e.st));
    check({e.nm, ".event"},   32'(event_a),  32'(e.ev));
    check({e.nm, ".level"},   32'(level_a),  32'(e.lv));
    check({e.nm, ".status2"}, 32'(status_b), 32'(e.st));
    check({e.nm, ".event2"},  32'(event_b),  32'(e.ev));
    check({e.nm, ".level2"},  32'(level_b),  32'(e.lv2));
  endtask

  // Monitor: one queued expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all(e);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic s, input logic a, input logic c,
                      input logic [7:0] o, input logic [7:0] f,
                      input logic [1:0] st, input logic ev,
                      input logic [3:0] lv, input logic [1:0] lv2, input string nm);
    exp_t e;
    @(negedge clk);
    strobe = s; ack = a; clear = c; data_or = o; data_first = f;
    e.nm = nm; e.st = st; e.ev = ev; e.lv = lv; e.lv2 = lv2;
    q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    strobe = 1'b0; ack = 1'b0; clear = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      fails++;
      tests++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic win_ack(input logic [3:0] lv, input logic [1:0] lv2, input string nm);
    step(1, 0, 0, 8'hFF, 8'h00, 2'b00, 0, lv - 4'd1, (lv2 == 2'd3 && lv > 4'd3) ? 2'd3 : lv2 - 2'd1, {nm, "_s1"});
    step(1, 0, 0, 8'hFF, 8'h00, 2'b11, 1, lv, lv2, {nm, "_s2"});
    step(0, 1, 0, 8'h00, 8'h00, 2'b00, 0, lv, lv2, {nm, "_ack"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset, observed asynchronously.
    #1 rst_n = 1'b0;
    #1;
    check_all('{nm: "reset", st: 2'b00, ev: 1'b0, lv: 4'd0, lv2: 2'd0});
    @(negedge clk) rst_n = 1'b1;

    // Win in two strobes, then sticky behaviour and ack+strobe.
    step(1, 0, 0, 8'hFF, 8'h00, 2'b00, 0, 4'd0, 2'd0, "win_s1");
    step(1, 0, 0, 8'hFF, 8'h00, 2'b11, 1, 4'd1, 2'd1, "win_s2");
    step(0, 0, 0, 8'h00, 8'h00, 2'b11, 0, 4'd1, 2'd1, "win_hold");
    step(1, 0, 0, 8'h18, 8'h08, 2'b11, 0, 4'd1, 2'd1, "sticky_1");
    step(1, 0, 0, 8'h18, 8'h08, 2'b11, 0, 4'd1, 2'd1, "sticky_2");
    step(1, 1, 0, 8'hFF, 8'h00, 2'b00, 0, 4'd1, 2'd1, "ack_strobe");
    step(1, 0, 0, 8'hFF, 8'h00, 2'b00, 0, 4'd1, 2'd1, "cnt0_s1");
    step(1, 0, 0, 8'hFF, 8'h00, 2'b11, 1, 4'd2, 2'd2, "cnt0_s2");
    step(0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 4'd2, 2'd2, "ack2");
    step(0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 4'd2, 2'd2, "ack_play");

    // Lose, and a NONE sample breaking the run.
    step(1, 0, 0, 8'h18, 8'h08, 2'b00, 0, 4'd2, 2'd2, "lose_s1");
    step(1, 0, 0, 8'h18, 8'h08, 2'b01, 1, 4'd2, 2'd2, "lose_s2");
    step(0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 4'd2, 2'd2, "lose_ack");
    step(1, 0, 0, 8'h18, 8'h08, 2'b00, 0, 4'd2, 2'd2, "brk_s1");
    step(1, 0, 0, 8'h08, 8'h08, 2'b00, 0, 4'd2, 2'd2, "brk_none");
    step(1, 0, 0, 8'h18, 8'h08, 2'b00, 0, 4'd2, 2'd2, "brk_s2");
    step(0, 0, 0, 8'h18, 8'h08, 2'b00, 0, 4'd2, 2'd2, "brk_idle");
    step(1, 0, 0, 8'h08, 8'h08, 2'b00, 0, 4'd2, 2'd2, "brk_none2");
    step(1, 0, 0, 8'h18, 8'h08, 2'b00, 0, 4'd2, 2'd2, "brk_s3");
    step(1, 0, 0, 8'h18, 8'h08, 2'b01, 1, 4'd2, 2'd2, "brk_s4");
    step(0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 4'd2, 2'd2, "brk_ack");

    // Candidate switches in both directions.
    step(1, 0, 0, 8'hFF, 8'h00, 2'b00, 0, 4'd2, 2'd2, "sw_win");
    step(1, 0, 0, 8'h18, 8'h08, 2'b00, 0, 4'd2, 2'd2, "sw_lose1");
    step(1, 0, 0, 8'h18, 8'h08, 2'b01, 1, 4'd2, 2'd2, "sw_lose2");
    step(0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 4'd2, 2'd2, "sw_ack1");
    step(1, 0, 0, 8'h18, 8'h08, 2'b00, 0, 4'd2, 2'd2, "sw2_lose");
    step(1, 0, 0, 8'hFF, 8'hFF, 2'b00, 0, 4'd2, 2'd2, "sw2_win1");
    step(1, 0, 0, 8'hFF, 8'hFF, 2'b11, 1, 4'd3, 2'd3, "sw2_win2");
    step(0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 4'd3, 2'd3, "sw2_ack");

    // Saturation of the 2-bit level counter.
    win_ack(4'd4, 2'd3, "sat4");
    win_ack(4'd5, 2'd3, "sat5");

    // Async reset while ARMED.
    step(1, 0, 0, 8'hFF, 8'h00, 2'b00, 0, 4'd5, 2'd3, "armed");
    drain();
    #2 rst_n = 1'b0;
    #1;
    check_all('{nm: "reset_armed", st: 2'b00, ev: 1'b0, lv: 4'd0, lv2: 2'd0});
    @(negedge clk) rst_n = 1'b1;

    // Clear has priority over strobe, both in terminal and ARMED.
    step(1, 0, 0, 8'hFF, 8'h00, 2'b00, 0, 4'd0, 2'd0, "post_rst_s1");
    step(1, 0, 0, 8'hFF, 8'h00, 2'b11, 1, 4'd1, 2'd1, "post_rst_s2");
    step(1, 0, 1, 8'hFF, 8'h00, 2'b00, 0, 4'd0, 2'd0, "clear_win");
    step(1, 0, 0, 8'hFF, 8'h00, 2'b00, 0, 4'd0, 2'd0, "clr_s1");
    step(1, 0, 1, 8'hFF, 8'h00, 2'b00, 0, 4'd0, 2'd0, "clear_armed");
    step(1, 0, 0, 8'hFF, 8'h00, 2'b00, 0, 4'd0, 2'd0, "clr_s2");
    step(1, 0, 0, 8'hFF, 8'h00, 2'b11, 1, 4'd1, 2'd1, "clr_s3");
    step(0, 0, 0, 8'h00, 8'h00, 2'b11, 0, 4'd1, 2'd1, "event_drop");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
